// File: rtl/div_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl_if
// Bundles the handshake and data signals of div_issue_ctrl.
//   in_valid/in_ready/in_a/in_b      : operand pair handshake (into controller)
//   div_a/div_b                      : FIFO head presented to the divider
//   div_q/div_r                      : combinational divider result
//   out_valid/out_ready/out_q/out_r  : registered result handshake
//   out_dbz                          : result came from a zero divisor
//   done_count                       : retired results, wraps 255 -> 0
// master : the environment (producer, divider, consumer)
// slave  : the controller
// ---------------------------------------------------------------------------
interface div_issue_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dbz;
  logic [7:0]       done_count;

  modport master (
    output in_valid, in_a, in_b, div_q, div_r, out_ready,
    input  in_ready, div_a, div_b, out_valid, out_q, out_r, out_dbz, done_count
  );

  modport slave (
    input  in_valid, in_a, in_b, div_q, div_r, out_ready,
    output in_ready, div_a, div_b, out_valid, out_q, out_r, out_dbz, done_count
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// ---------------------------------------------------------------------------
// div_issue_ctrl
// Issue/retire controller for an external combinational array divider.
// Operand pairs are buffered in a DEPTH-entry FIFO; the head is driven to the
// divider and its quotient/remainder are captured into a registered result
// port. Divide-by-zero is detected here and produces q = all ones, r = a.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : div_issue_ctrl_if.slave (operand, divider and result handshakes)
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  div_issue_ctrl_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem_a [DEPTH];
  logic [WIDTH-1:0] r_mem_b [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_q;
  logic [WIDTH-1:0] r_out_r;
  logic             r_out_dbz;
  logic [7:0]       r_done_count;

  logic             w_in_ready;
  logic             w_nonempty;
  logic             w_push;
  logic             w_retire;
  logic             w_consume;
  logic [WIDTH-1:0] w_head_a;
  logic [WIDTH-1:0] w_head_b;

  // in_ready looks only at registered occupancy so it never combinationally
  // depends on the consumer's out_ready.
  assign w_in_ready = !rst && (r_count < CW'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.in_valid && w_in_ready;
  assign w_retire   = w_nonempty && (!r_out_valid || bus.out_ready);
  assign w_consume  = r_out_valid && bus.out_ready;

  assign w_head_a   = w_nonempty ? r_mem_a[r_rptr] : '0;
  assign w_head_b   = w_nonempty ? r_mem_b[r_rptr] : '0;

  assign bus.in_ready   = w_in_ready;
  assign bus.div_a      = w_head_a;
  assign bus.div_b      = w_head_b;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_q      = r_out_q;
  assign bus.out_r      = r_out_r;
  assign bus.out_dbz    = r_out_dbz;
  assign bus.done_count = r_done_count;

  // FIFO: pointers and storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_a[i] <= '0;
        r_mem_b[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_a[r_wptr] <= bus.in_a;
        r_mem_b[r_wptr] <= bus.in_b;
        r_wptr          <= r_wptr + PW'(1);
      end
      if (w_retire) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Result register: a retire reloads it even while the previous result is
  // being consumed, so streaming has no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_q      <= '0;
      r_out_r      <= '0;
      r_out_dbz    <= 1'b0;
      r_done_count <= '0;
    end else begin
      if (w_consume) begin
        r_done_count <= r_done_count + 8'd1;
      end
      if (w_retire) begin
        r_out_valid <= 1'b1;
        if (w_head_b == '0) begin
          // Divider output is meaningless for b == 0; substitute the
          // conventional all-ones quotient and pass the dividend through.
          r_out_q   <= '1;
          r_out_r   <= w_head_a;
          r_out_dbz <= 1'b1;
        end else begin
          r_out_q   <= bus.div_q;
          r_out_r   <= bus.div_r;
          r_out_dbz <= 1'b0;
        end
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

  div_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Divider stand-in: true division for nonzero divisors, random junk for a
  // zero divisor (the controller must ignore it).
  logic [WIDTH-1:0] junk_q = '0;
  logic [WIDTH-1:0] junk_r = '0;
  always_comb begin
    bus.div_q = junk_q;
    bus.div_r = junk_r;
    if (bus.div_b != '0) begin
      bus.div_q = bus.div_a / bus.div_b;
      bus.div_r = bus.div_a % bus.div_b;
    end
  end

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pending operand pairs plus one result slot.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t            mq[$];
  logic             m_ov   = 1'b0;
  logic [WIDTH-1:0] m_q    = '0;
  logic [WIDTH-1:0] m_r    = '0;
  logic             m_dbz  = 1'b0;
  logic [7:0]       m_done = '0;

  always @(posedge clk or posedge rst) begin
    bit    do_push, do_retire, do_consume;
    pair_t h;
    if (rst) begin
      mq.delete();
      m_ov   = 1'b0;
      m_q    = '0;
      m_r    = '0;
      m_dbz  = 1'b0;
      m_done = '0;
    end else begin
      do_push    = bus.in_valid && (mq.size() < DEPTH);
      do_consume = m_ov && bus.out_ready;
      do_retire  = (mq.size() > 0) && (!m_ov || bus.out_ready);
      if (do_consume) m_done = m_done + 8'd1;
      if (do_retire) begin
        h = mq.pop_front();
        if (h.b == 0) begin
          m_q = '1; m_r = h.a; m_dbz = 1'b1;
        end else begin
          m_q = h.a / h.b; m_r = h.a % h.b; m_dbz = 1'b0;
        end
        m_ov = 1'b1;
      end else if (do_consume) begin
        m_ov = 1'b0;
      end
      if (do_push) mq.push_back(pair_t'{a: bus.in_a, b: bus.in_b});
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready",   32'(bus.in_ready),   32'(!rst && (mq.size() < DEPTH)));
      chk("out_valid",  32'(bus.out_valid),  32'(m_ov));
      chk("done_count", 32'(bus.done_count), 32'(m_done));
      chk("div_a",      32'(bus.div_a),      (mq.size() > 0) ? 32'(mq[0].a) : 32'd0);
      chk("div_b",      32'(bus.div_b),      (mq.size() > 0) ? 32'(mq[0].b) : 32'd0);
      if (m_ov) begin
        chk("out_q",   32'(bus.out_q),   32'(m_q));
        chk("out_r",   32'(bus.out_r),   32'(m_r));
        chk("out_dbz", 32'(bus.out_dbz), 32'(m_dbz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    junk_q = WIDTH'($urandom);
    junk_r = WIDTH'($urandom);
  endtask

  task automatic push1(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit acc;
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    for (int i = 0; i < 64; i++) begin
      acc = bus.in_ready;
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] d0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #1 rst = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),   32'd0);
    chk("rst_out_valid", 32'(bus.out_valid),  32'd0);
    chk("rst_out_q",     32'(bus.out_q),      32'd0);
    chk("rst_out_r",     32'(bus.out_r),      32'd0);
    chk("rst_out_dbz",   32'(bus.out_dbz),    32'd0);
    chk("rst_done",      32'(bus.done_count), 32'd0);
    chk("rst_div_a",     32'(bus.div_a),      32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 13 / 3
    push1(4'd13, 4'd3);
    tick();
    chk("d13_valid", 32'(bus.out_valid), 32'd1);
    chk("d13_q",     32'(bus.out_q),     32'd4);
    chk("d13_r",     32'(bus.out_r),     32'd1);
    chk("d13_dbz",   32'(bus.out_dbz),   32'd0);
    tick();
    chk("d13_done",  32'(bus.done_count), 32'd1);

    // 9 / 0
    push1(4'd9, 4'd0);
    tick();
    chk("d9_valid", 32'(bus.out_valid), 32'd1);
    chk("d9_q",     32'(bus.out_q),     32'd15);
    chk("d9_r",     32'(bus.out_r),     32'd9);
    chk("d9_dbz",   32'(bus.out_dbz),   32'd1);
    tick();

    // Backpressure then release
    bus.out_ready = 1'b0;
    push1(4'd15, 4'd4);
    push1(4'd7, 4'd2);
    push1(4'd8, 4'd8);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_q0", 32'(bus.out_q), 32'd3);
    chk("bp_r0", 32'(bus.out_r), 32'd3);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_v1", 32'(bus.out_valid), 32'd1);
    chk("bp_q1", 32'(bus.out_q), 32'd3);
    chk("bp_r1", 32'(bus.out_r), 32'd1);
    tick();
    chk("bp_v2", 32'(bus.out_valid), 32'd1);
    chk("bp_q2", 32'(bus.out_q), 32'd1);
    chk("bp_r2", 32'(bus.out_r), 32'd0);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // Streaming 20 nonzero-divisor pairs
    d0 = bus.done_count;
    for (int i = 0; i < 20; i++) begin
      push1(WIDTH'($urandom), WIDTH'($urandom_range(1, 15)));
      if (i > 0) chk("stream_no_bubble", 32'(bus.out_valid), 32'd1);
    end
    tick();
    tick();
    tick();
    chk("stream_count", 32'(bus.done_count - d0), 32'd20);

    // Random traffic with random backpressure and zero divisors
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_a      = WIDTH'($urandom);
      bus.in_b      = ($urandom_range(0, 4) == 0) ? '0 : WIDTH'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Reset mid-operation with FIFO full and a held result
    bus.out_ready = 1'b0;
    push1(4'd1, 4'd1);
    push1(4'd2, 4'd1);
    push1(4'd3, 4'd1);
    chk("mid_full", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_out_valid", 32'(bus.out_valid),  32'd0);
    chk("mid_done",      32'(bus.done_count), 32'd0);
    chk("mid_in_ready",  32'(bus.in_ready),   32'd0);
    chk("mid_div_a",     32'(bus.div_a),      32'd0);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    push1(4'd13, 4'd3);
    tick();
    chk("mid_new_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_new_q",     32'(bus.out_q),     32'd4);
    chk("mid_new_r",     32'(bus.out_r),     32'd1);

    // Counter wrap: 257 retired results
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 257; i++) push1(WIDTH'($urandom), WIDTH'($urandom));
    for (int i = 0; i < 4; i++) tick();
    chk("wrap_done", 32'(bus.done_count), 32'd1);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
